// File: rtl/intersection_pkg.sv
// intersection_pkg: shared state, table-select codes and default times
// for the multi-phase intersection controller.
package intersection_pkg;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_EXTEND = 2'd1,
    S_YELLOW = 2'd2,
    S_WALK   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_GREEN  = 2'd0;
  localparam logic [1:0] SEL_EXT    = 2'd1;
  localparam logic [1:0] SEL_YELLOW = 2'd2;
  localparam logic [1:0] SEL_WALK   = 2'd3;

  localparam int DEF_GREEN  = 6;
  localparam int DEF_EXT    = 3;
  localparam int DEF_YELLOW = 2;
  localparam int DEF_WALK   = 3;
  localparam int MIN_TIME   = 1;

  function automatic logic [1:0] sel_of(state_t s);
    logic [1:0] r;
    case (s)
      S_GREEN:  r = SEL_GREEN;
      S_EXTEND: r = SEL_EXT;
      S_YELLOW: r = SEL_YELLOW;
      default:  r = SEL_WALK;
    endcase
    return r;
  endfunction

  function automatic int def_time(logic [1:0] sel);
    int r;
    case (sel)
      SEL_GREEN:  r = DEF_GREEN;
      SEL_EXT:    r = DEF_EXT;
      SEL_YELLOW: r = DEF_YELLOW;
      default:    r = DEF_WALK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/intersection_ctrl_tick_timer.sv
// tick_timer: one-second tick divider plus loadable seconds down-counter.
// expired fires on the tick that sees a count of 1.
module tick_timer #(
  parameter int TW = 4,
  parameter int TICK_DIV = 27_000_000,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr_div,
  input  logic [TW-1:0] value,
  output logic          expired
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div;
  logic [TW-1:0] cnt;
  logic          tick;

  assign tick    = (div == DIV_LAST);
  assign expired = tick && (cnt == TW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      cnt <= RST_VAL;
    end else begin
      if (clr_div || tick) div <= '0;
      else                 div <= div + 1'b1;
      if (load)
        cnt <= value;
      else if (tick && cnt != TW'(1))
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: round-robin multi-phase traffic controller with
// per-phase timing table, sensor extension and latched walk requests.
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TW = 4,
  parameter int TICK_DIV = 27_000_000
) (
  input  logic                          clk,
  input  logic                          g_reset,
  input  logic [NUM_PHASES-1:0]         sensor,
  input  logic [NUM_PHASES-1:0]         walk_request,
  input  logic                          reprogram,
  input  logic [1:0]                    param_sel,
  input  logic [$clog2(NUM_PHASES)-1:0] param_phase,
  input  logic [TW-1:0]                 param_value,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic [NUM_PHASES-1:0]         walk,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase
);

  localparam int NP = NUM_PHASES;
  localparam int PW = $clog2(NP);
  localparam logic [PW-1:0] LAST = PW'(NP - 1);

  state_t        state, nxt_state;
  logic [PW-1:0] p, nxt_p, p_inc;
  logic [NP-1:0] pend, pend_clr, oh, nxt_oh;
  logic [NP-1:0] g_n, y_n, w_n;
  logic [TW-1:0] tbl [NP][4];
  logic [TW-1:0] wr_val, load_val;
  logic          row_ok, wr_en, go, expired;

  assign p_inc  = (p == LAST) ? '0 : p + 1'b1;
  assign oh     = NP'(1) << p;
  assign nxt_oh = NP'(1) << nxt_p;
  assign row_ok = int'(param_phase) < NP;
  assign wr_en  = reprogram && row_ok;
  assign wr_val = (param_value == '0) ? TW'(MIN_TIME) : param_value;
  assign active_phase = p;

  always_comb begin
    nxt_state = state;
    nxt_p     = p;
    go        = 1'b0;
    if (reprogram) begin
      nxt_state = S_GREEN;
      nxt_p     = '0;
      go        = 1'b1;
    end else if (expired) begin
      go = 1'b1;
      unique case (state)
        S_GREEN:  nxt_state = sensor[p] ? S_EXTEND : S_YELLOW;
        S_EXTEND: nxt_state = S_YELLOW;
        S_YELLOW: begin
          if (pend[p]) begin
            nxt_state = S_WALK;
          end else begin
            nxt_state = S_GREEN;
            nxt_p     = p_inc;
          end
        end
        S_WALK: begin
          nxt_state = S_GREEN;
          nxt_p     = p_inc;
        end
      endcase
    end
  end

  // A same-cycle write to the entry being loaded is forwarded.
  always_comb begin
    load_val = tbl[nxt_p][sel_of(nxt_state)];
    if (wr_en && param_phase == nxt_p &&
        param_sel == sel_of(nxt_state))
      load_val = wr_val;
  end

  always_comb begin
    g_n = '0;
    y_n = '0;
    w_n = '0;
    unique case (1'b1)
      nxt_state == S_GREEN,
      nxt_state == S_EXTEND: g_n = nxt_oh;
      nxt_state == S_YELLOW: y_n = nxt_oh;
      default:               w_n = nxt_oh;
    endcase
  end

  assign pend_clr = (state == S_WALK && expired && !reprogram)
                  ? oh : '0;

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      state  <= S_GREEN;
      p      <= '0;
      green  <= NP'(1);
      yellow <= '0;
      red    <= ~NP'(1);
      walk   <= '0;
    end else if (go) begin
      state  <= nxt_state;
      p      <= nxt_p;
      green  <= g_n;
      yellow <= y_n;
      red    <= ~(g_n | y_n);
      walk   <= w_n;
    end
  end

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) pend <= '0;
    else         pend <= (pend & ~pend_clr) | walk_request;
  end

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      for (int r = 0; r < NP; r++)
        for (int s = 0; s < 4; s++)
          tbl[r][s] <= TW'(def_time(2'(s)));
    end else if (wr_en) begin
      tbl[param_phase][param_sel] <= wr_val;
    end
  end

  tick_timer #(
    .TW      (TW),
    .TICK_DIV(TICK_DIV),
    .RST_VAL (TW'(DEF_GREEN))
  ) u_timer (
    .clk    (clk),
    .rst    (g_reset),
    .load   (go),
    .clr_div(go && !reprogram),
    .value  (load_val),
    .expired(expired)
  );

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed scenarios for intersection_ctrl
// with TICK_DIV=4, NUM_PHASES=2.
module tb_intersection_ctrl;

  localparam int NP = 2;
  localparam int TW = 4;
  localparam int TD = 4;
  localparam int K_G = 0;
  localparam int K_Y = 1;
  localparam int K_W = 2;

  logic       clk = 1'b0;
  logic       g_reset = 1'b1;
  logic [1:0] sensor = '0;
  logic [1:0] walk_request = '0;
  logic       reprogram = 1'b0;
  logic [1:0] param_sel = '0;
  logic [0:0] param_phase = '0;
  logic [3:0] param_value = '0;
  logic [1:0] green, yellow, red, walk;
  logic [0:0] active_phase;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intersection_ctrl #(
    .NUM_PHASES(NP),
    .TW        (TW),
    .TICK_DIV  (TD)
  ) dut (
    .clk         (clk),
    .g_reset     (g_reset),
    .sensor      (sensor),
    .walk_request(walk_request),
    .reprogram   (reprogram),
    .param_sel   (param_sel),
    .param_phase (param_phase),
    .param_value (param_value),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .walk        (walk),
    .active_phase(active_phase)
  );

  // Expected {green,yellow,red,walk,active_phase} for a lamp kind/phase.
  function automatic logic [8:0] lamps(int k, int ph);
    logic [1:0] oh, g, y, r, w;
    oh = 2'b01 << ph;
    g = (k == K_G) ? oh : 2'b00;
    y = (k == K_Y) ? oh : 2'b00;
    w = (k == K_W) ? oh : 2'b00;
    r = ~(g | y);
    return {g, y, r, w, 1'(ph)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    g_reset = 1'b1;
    sensor = '0;
    walk_request = '0;
    reprogram = 1'b0;
    @(negedge clk);
    g_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    g_reset = 1'b1;
    repeat (2) @(negedge clk);
    obs = {green, yellow, red, walk, active_phase};
    checks++;
    if (obs !== lamps(K_G, 0)) begin
      failures++;
      $display("FAIL reset_lamps got=%b exp=%b", obs, lamps(K_G, 0));
    end
    checks++;
    if (dut.pend !== 2'b00) begin
      failures++;
      $display("FAIL reset_pend got=%b exp=00", dut.pend);
    end
  endtask

  task automatic test_free_run();
    int kd[5] = '{K_G, K_Y, K_G, K_Y, K_G};
    int ph[5] = '{0, 0, 1, 1, 0};
    int ln[5] = '{24, 8, 24, 8, 4};
    logic [8:0] obs, exp_v;
    logic bad;
    do_reset();
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < ln[s]; c++) begin
        obs = {green, yellow, red, walk, active_phase};
        exp_v = lamps(kd[s], ph[s]);
        checks++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL free_run seg=%0d cyc=%0d got=%b exp=%b",
                   s, c, obs, exp_v);
        end
        bad = !$onehot0(~red);
        for (int i = 0; i < NP; i++)
          if (!$onehot({green[i], yellow[i], red[i]})) bad = 1'b1;
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL invariant seg=%0d cyc=%0d g=%b y=%b r=%b exp=legal",
                   s, c, green, yellow, red);
        end
        @(negedge clk);
      end
  endtask

  task automatic test_extend();
    int kd[4] = '{K_G, K_Y, K_G, K_Y};
    int ph[4] = '{0, 0, 1, 1};
    int ln[4] = '{36, 8, 24, 4};
    logic [8:0] obs, exp_v;
    do_reset();
    sensor = 2'b01;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < ln[s]; c++) begin
        obs = {green, yellow, red, walk, active_phase};
        exp_v = lamps(kd[s], ph[s]);
        checks++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL extend seg=%0d cyc=%0d got=%b exp=%b",
                   s, c, obs, exp_v);
        end
        @(negedge clk);
      end
    sensor = '0;
  endtask

  task automatic test_walk();
    int kd[6] = '{K_G, K_Y, K_G, K_Y, K_W, K_G};
    int ph[6] = '{0, 0, 1, 1, 1, 0};
    int ln[6] = '{24, 8, 24, 8, 12, 4};
    logic [8:0] obs, exp_v;
    do_reset();
    for (int s = 0; s < 6; s++)
      for (int c = 0; c < ln[s]; c++) begin
        obs = {green, yellow, red, walk, active_phase};
        exp_v = lamps(kd[s], ph[s]);
        checks++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL walk seg=%0d cyc=%0d got=%b exp=%b",
                   s, c, obs, exp_v);
        end
        if (s == 3 && c == 0) begin
          checks++;
          if (dut.pend !== 2'b10) begin
            failures++;
            $display("FAIL walk_pend_set got=%b exp=10", dut.pend);
          end
        end
        if (s == 5 && c == 0) begin
          checks++;
          if (dut.pend !== 2'b00) begin
            failures++;
            $display("FAIL walk_pend_clr got=%b exp=00", dut.pend);
          end
        end
        walk_request = (s == 0 && c == 5) ? 2'b10 : 2'b00;
        @(negedge clk);
      end
  endtask

  task automatic test_reprogram();
    int kd[5] = '{K_G, K_Y, K_G, K_Y, K_G};
    int ph[5] = '{0, 0, 1, 1, 0};
    int ln[5] = '{21, 8, 24, 4, 4};
    logic [8:0] obs, exp_v;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      obs = {green, yellow, red, walk, active_phase};
      checks++;
      if (obs !== lamps(K_G, 0)) begin
        failures++;
        $display("FAIL reprog_pre cyc=%0d got=%b exp=%b",
                 c, obs, lamps(K_G, 0));
      end
      @(negedge clk);
    end
    reprogram = 1'b1;
    param_sel = 2'd2;
    param_phase = 1'b1;
    param_value = 4'd0;
    @(negedge clk);
    reprogram = 1'b0;
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < ln[s]; c++) begin
        obs = {green, yellow, red, walk, active_phase};
        exp_v = lamps(kd[s], ph[s]);
        checks++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL reprogram seg=%0d cyc=%0d got=%b exp=%b",
                   s, c, obs, exp_v);
        end
        @(negedge clk);
      end
  endtask

  task automatic test_reset_mid_walk();
    int kd[3] = '{K_G, K_Y, K_W};
    int ln[3] = '{24, 8, 5};
    logic [8:0] obs, exp_v;
    do_reset();
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < ln[s]; c++) begin
        obs = {green, yellow, red, walk, active_phase};
        exp_v = lamps(kd[s], 0);
        checks++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL rst_walk seg=%0d cyc=%0d got=%b exp=%b",
                   s, c, obs, exp_v);
        end
        walk_request = (s == 0 && c == 2) ? 2'b01 : 2'b00;
        @(negedge clk);
      end
    #2 g_reset = 1'b1;
    #1;
    obs = {green, yellow, red, walk, active_phase};
    checks++;
    if (obs !== lamps(K_G, 0)) begin
      failures++;
      $display("FAIL rst_async_lamps got=%b exp=%b", obs, lamps(K_G, 0));
    end
    checks++;
    if (dut.pend !== 2'b00) begin
      failures++;
      $display("FAIL rst_async_pend got=%b exp=00", dut.pend);
    end
    @(negedge clk);
    g_reset = 1'b0;
    for (int c = 0; c < 26; c++) begin
      obs = {green, yellow, red, walk, active_phase};
      exp_v = lamps(c < 24 ? K_G : K_Y, 0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL rst_rerun cyc=%0d got=%b exp=%b", c, obs, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_collision();
    int kd[8] = '{K_G, K_Y, K_W, K_G, K_Y, K_G, K_Y, K_W};
    int ph[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
    int ln[8] = '{24, 8, 12, 24, 8, 24, 8, 4};
    logic [8:0] obs, exp_v;
    do_reset();
    walk_request = 2'b01;
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < ln[s]; c++) begin
        obs = {green, yellow, red, walk, active_phase};
        exp_v = lamps(kd[s], ph[s]);
        checks++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL collision seg=%0d cyc=%0d got=%b exp=%b",
                   s, c, obs, exp_v);
        end
        if (s == 3 && c == 0) begin
          checks++;
          if (dut.pend !== 2'b01) begin
            failures++;
            $display("FAIL collision_pend got=%b exp=01", dut.pend);
          end
        end
        @(negedge clk);
      end
    walk_request = '0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_reprogram();
    test_walk();
    test_extend();
    test_reset_mid_walk();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
